// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, bubble instruction, PC step.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_INC = 4;

  // Wide enough for any INSTR_W in use; users truncate to their width.
  localparam logic [63:0] BUBBLE_INSTR = 64'h0;

  typedef struct packed {
    fetch_state_t state;
    logic         kill;
  } fetch_dbg_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port. The memory accepts req in the same cycle; rvalid
// returns one or more cycles later with rdata, and only one request is ever outstanding.
interface fetch_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) ();
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with freeze (hold everything) and flush (clear valid only).
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               flush,
  input  logic               load,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic [INSTR_W-1:0] next_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  // Flush beats hold; without a load, an unfrozen register turns into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= INSTR_W'(BUBBLE_INSTR);
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      valid <= load;
      if (load) begin
        pc    <= next_pc;
        instr <= next_instr;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one fetch at a time, feeds the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hazard_detected,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  fetch_stage_if.master      imem,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output fetch_dbg_t         dbg
);

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, req_pc, inc_pc;
  logic               kill;
  logic [INSTR_W-1:0] buffer;
  logic               deliver;
  logic [INSTR_W-1:0] deliver_instr;

  assign inc_pc = req_pc + ADDR_W'(PC_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if (!branch_taken) state_next = ST_WAIT;
      ST_WAIT: begin
        if (imem.rvalid) begin
          if (branch_taken || kill || !hazard_detected) state_next = ST_FETCH;
          else                                          state_next = ST_HOLD;
        end
      end
      ST_HOLD:  if (branch_taken || !hazard_detected) state_next = ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem.req      = (state == ST_FETCH) && !branch_taken;
    imem.addr     = pc;
    deliver       = 1'b0;
    deliver_instr = imem.rdata;
    if (!branch_taken && !hazard_detected) begin
      if (state == ST_WAIT) deliver = imem.rvalid && !kill;
      if (state == ST_HOLD) begin
        deliver       = 1'b1;
        deliver_instr = buffer;
      end
    end
  end

  // kill marks an in-flight fetch whose response must be dropped after a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
      buffer <= '0;
    end else if (branch_taken) begin
      pc <= branch_addr;
      if (state == ST_WAIT) kill <= !imem.rvalid;
    end else begin
      case (state)
        ST_FETCH: req_pc <= pc;
        ST_WAIT: begin
          if (imem.rvalid) begin
            if (kill) begin
              kill <= 1'b0;
            end else begin
              pc <= inc_pc;
              if (hazard_detected) buffer <= imem.rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  fetch_stage_if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hazard_detected),
    .flush      (branch_taken),
    .load       (deliver),
    .next_pc    (inc_pc),
    .next_instr (deliver_instr),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

  assign dbg.state = state;
  assign dbg.kill  = kill;

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-by-cycle directed bench for fetch_stage; instruction memory is driven by the vectors.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hazard_detected = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  fetch_dbg_t  dbg;

  fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem            (imem),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .dbg             (dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         hz;
    logic         br;
    logic [31:0]  ba;
    logic         rv;
    logic [31:0]  rd;
    logic         e_req;
    logic [31:0]  e_addr;
    logic         e_valid;
    logic [31:0]  e_pc;
    logic [31:0]  e_instr;
    fetch_state_t e_state;
    logic         e_kill;
  } vec_t;

  function automatic vec_t mk(logic hz, logic br, logic [31:0] ba, logic rv, logic [31:0] rd,
                              logic e_req, logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_pc, logic [31:0] e_instr,
                              fetch_state_t e_state, logic e_kill);
    vec_t v;
    v.hz = hz; v.br = br; v.ba = ba; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_state = e_state; v.e_kill = e_kill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, "_req"},   32'(imem.req), 32'(v.e_req));
    chk({tag, "_addr"},  imem.addr,     v.e_addr);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v.e_valid));
    chk({tag, "_pc"},    if_pc,         v.e_pc);
    chk({tag, "_instr"}, if_instr,      v.e_instr);
    chk({tag, "_state"}, 32'(dbg.state), 32'(v.e_state));
    chk({tag, "_kill"},  32'(dbg.kill),  32'(v.e_kill));
  endtask

  // Called at posedge+1: drive this cycle's inputs, check mid-cycle, advance one edge.
  task automatic apply(input string tag, input vec_t v);
    hazard_detected = v.hz;
    branch_taken    = v.br;
    branch_addr     = v.ba;
    imem.rvalid     = v.rv;
    imem.rdata      = v.rd;
    #3;
    check_outputs(tag, v);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I0 = 32'hE3A00001;

  vec_t vecs[30];

  initial begin
    imem.rvalid = 1'b0;
    imem.rdata  = '0;

    //              hz br ba        rv rd            req addr       v  pc         instr         state     k
    vecs[0]  = mk(0, 0, 0,         0, 0,            0, 32'h0,     0, 32'h0,    32'h0,        ST_IDLE,  0);
    vecs[1]  = mk(0, 0, 0,         0, 0,            1, 32'h0,     0, 32'h0,    32'h0,        ST_FETCH, 0);
    vecs[2]  = mk(0, 0, 0,         1, I0,           0, 32'h0,     0, 32'h0,    32'h0,        ST_WAIT,  0);
    vecs[3]  = mk(0, 0, 0,         0, 0,            1, 32'h4,     1, 32'h4,    I0,           ST_FETCH, 0);
    vecs[4]  = mk(0, 0, 0,         1, 32'h11111111, 0, 32'h4,     0, 32'h4,    I0,           ST_WAIT,  0);
    vecs[5]  = mk(0, 0, 0,         0, 0,            1, 32'h8,     1, 32'h8,    32'h11111111, ST_FETCH, 0);
    vecs[6]  = mk(0, 0, 0,         0, 0,            0, 32'h8,     0, 32'h8,    32'h11111111, ST_WAIT,  0);
    // freeze across the arrival of the 0x8 response
    vecs[7]  = mk(1, 0, 0,         1, 32'h22222222, 0, 32'h8,     0, 32'h8,    32'h11111111, ST_WAIT,  0);
    vecs[8]  = mk(1, 0, 0,         0, 0,            0, 32'hC,     0, 32'h8,    32'h11111111, ST_HOLD,  0);
    vecs[9]  = mk(1, 0, 0,         0, 0,            0, 32'hC,     0, 32'h8,    32'h11111111, ST_HOLD,  0);
    vecs[10] = mk(0, 0, 0,         0, 0,            0, 32'hC,     0, 32'h8,    32'h11111111, ST_HOLD,  0);
    vecs[11] = mk(0, 0, 0,         0, 0,            1, 32'hC,     1, 32'hC,    32'h22222222, ST_FETCH, 0);
    vecs[12] = mk(0, 0, 0,         1, 32'h33333333, 0, 32'hC,     0, 32'hC,    32'h22222222, ST_WAIT,  0);
    vecs[13] = mk(0, 0, 0,         0, 0,            1, 32'h10,    1, 32'h10,   32'h33333333, ST_FETCH, 0);
    // branch while 0x10 is in flight; its response arrives two cycles later
    vecs[14] = mk(0, 1, 32'h100,   0, 0,            0, 32'h10,    0, 32'h10,   32'h33333333, ST_WAIT,  0);
    vecs[15] = mk(0, 0, 0,         0, 0,            0, 32'h100,   0, 32'h10,   32'h33333333, ST_WAIT,  1);
    vecs[16] = mk(0, 0, 0,         1, 32'h44444444, 0, 32'h100,   0, 32'h10,   32'h33333333, ST_WAIT,  1);
    vecs[17] = mk(0, 0, 0,         0, 0,            1, 32'h100,   0, 32'h10,   32'h33333333, ST_FETCH, 0);
    // branch and response in the same WAIT cycle
    vecs[18] = mk(0, 1, 32'h200,   1, 32'h55555555, 0, 32'h100,   0, 32'h10,   32'h33333333, ST_WAIT,  0);
    vecs[19] = mk(0, 0, 0,         0, 0,            1, 32'h200,   0, 32'h10,   32'h33333333, ST_FETCH, 0);
    // branch together with freeze in HOLD
    vecs[20] = mk(1, 0, 0,         1, 32'h66666666, 0, 32'h200,   0, 32'h10,   32'h33333333, ST_WAIT,  0);
    vecs[21] = mk(1, 1, 32'h300,   0, 0,            0, 32'h204,   0, 32'h10,   32'h33333333, ST_HOLD,  0);
    // branch in FETCH suppresses the request
    vecs[22] = mk(0, 1, 32'h400,   0, 0,            0, 32'h300,   0, 32'h10,   32'h33333333, ST_FETCH, 0);
    vecs[23] = mk(0, 0, 0,         0, 0,            1, 32'h400,   0, 32'h10,   32'h33333333, ST_FETCH, 0);
    vecs[24] = mk(0, 0, 0,         1, 32'h77777777, 0, 32'h400,   0, 32'h10,   32'h33333333, ST_WAIT,  0);
    vecs[25] = mk(0, 0, 0,         0, 0,            1, 32'h404,   1, 32'h404,  32'h77777777, ST_FETCH, 0);
    // back-to-back branches while a fetch is being killed
    vecs[26] = mk(0, 1, 32'h500,   0, 0,            0, 32'h404,   0, 32'h404,  32'h77777777, ST_WAIT,  0);
    vecs[27] = mk(0, 1, 32'h600,   0, 0,            0, 32'h500,   0, 32'h404,  32'h77777777, ST_WAIT,  1);
    vecs[28] = mk(0, 0, 0,         1, 32'h88888888, 0, 32'h600,   0, 32'h404,  32'h77777777, ST_WAIT,  1);
    vecs[29] = mk(0, 0, 0,         0, 0,            1, 32'h600,   0, 32'h404,  32'h77777777, ST_FETCH, 0);

    // reset values while rst_n is held low
    #2;
    chk("rst_req",   32'(imem.req), 32'h0);
    chk("rst_addr",  imem.addr,     32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_pc",    if_pc,         32'h0);
    chk("rst_instr", if_instr,      32'h0);
    chk("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    chk("rst_kill",  32'(dbg.kill),  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) apply($sformatf("row%0d", i), vecs[i]);

    // now in WAIT for 0x600; reset asynchronously mid-wait
    apply("to_wait", mk(0, 0, 0, 0, 0, 0, 32'h600, 0, 32'h404, 32'h77777777, ST_WAIT, 0));
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(dbg.state), 32'(ST_IDLE));
    chk("arst_addr",  imem.addr,      32'h0);
    chk("arst_valid", 32'(if_valid),  32'h0);
    chk("arst_pc",    if_pc,          32'h0);
    chk("arst_instr", if_instr,       32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // stale responses in IDLE and FETCH are ignored
    apply("stale_idle",  mk(0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0, 32'h0, ST_IDLE, 0));
    apply("stale_fetch", mk(0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h0, 0, 32'h0, 32'h0, ST_FETCH, 0));
    apply("restart_wait", mk(0, 0, 0, 1, 32'hAAAA0000, 0, 32'h0, 0, 32'h0, 32'h0, ST_WAIT, 0));
    // redirect to the top of the address space and watch the PC wrap
    apply("wrap_br",    mk(0, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h4, 1, 32'h4, 32'hAAAA0000, ST_FETCH, 0));
    apply("wrap_fetch", mk(0, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h4, 32'hAAAA0000, ST_FETCH, 0));
    apply("wrap_wait",  mk(0, 0, 0, 1, 32'hBBBBBBBB, 0, 32'hFFFFFFFC, 0, 32'h4, 32'hAAAA0000, ST_WAIT, 0));
    apply("wrap_done",  mk(0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'hBBBBBBBB, ST_FETCH, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
